// File: rtl/spi_slave_pkg.sv
// Shared SPI types and constants for the slave (and the master on the same link).
package spi_pkg;
  localparam int SPI_DATA_W = 8;
  localparam int SPI_CNT_W  = $clog2(SPI_DATA_W);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} spi_slv_state_t;
endpackage

// File: rtl/spi_slave_if.sv
// Byte-level TX/RX handshake bundle between spi_slave and its local consumer.
interface spi_slave_if;
  import spi_pkg::*;
  logic [SPI_DATA_W-1:0] tx_data_i;
  logic                  tx_valid_i;
  logic                  tx_ready_o;
  logic [SPI_DATA_W-1:0] rx_data_o;
  logic                  rx_valid_o;
  logic                  rx_ready_i;
  logic                  rx_overrun_o;
  logic                  busy_o;

  modport slave  (input  tx_data_i, tx_valid_i, rx_ready_i,
                  output tx_ready_o, rx_data_o, rx_valid_o, rx_overrun_o, busy_o);
  modport master (output tx_data_i, tx_valid_i, rx_ready_i,
                  input  tx_ready_o, rx_data_o, rx_valid_o, rx_overrun_o, busy_o);
endinterface

// File: rtl/spi_slave_edge_sync.sv
// Synchronizer chain plus one delay flop; emits synchronized level and edge strobes.
module spi_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    dly_d  = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~dly_q;
  assign fall_o  = ~level_o & dly_q;
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 byte responder, oversampled in clk_i. Define SPI_SLAVE_OVERRUN_EN to
// drop bytes arriving while rx_data_o is still unconsumed and raise a sticky overrun.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_DATA_W-1:0] IDLE_BYTE   = 8'h00
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          SCK,
  input  logic          CS,
  input  logic          MOSI,
  output logic          MISO,
  spi_slave_if.slave    bus
);
  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_mosi_edges;

  // CS idles high, so its chain resets high to avoid a phantom select after reset.
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk_i, .reset_i, .d_i(SCK), .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall));
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk_i, .reset_i, .d_i(CS), .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk_i, .reset_i, .d_i(MOSI), .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

  assign unused_mosi_edges = mosi_rise ^ mosi_fall ^ sck_lvl;

  spi_slv_state_t        state_q, state_d;
  logic [SPI_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SPI_DATA_W-1:0] shift_tx_q, shift_tx_d, shift_rx_q, shift_rx_d;
  logic [SPI_DATA_W-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
  logic                  hold_full_q, hold_full_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  miso_q, miso_d;
  logic                  overrun_q, overrun_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_tx_d  = shift_tx_q;
    shift_rx_d  = shift_rx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    miso_d      = miso_q;
    overrun_d   = overrun_q;

    if (rx_valid_q && bus.rx_ready_i) rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = '0;
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        if (hold_full_q) begin
          shift_tx_d  = hold_q;
          hold_full_d = 1'b0;
        end else begin
          shift_tx_d  = IDLE_BYTE;
        end
        miso_d  = shift_tx_d[SPI_DATA_W-1];
        state_d = SHIFT;
      end
      SHIFT: begin
        if (sck_rise) begin
          shift_rx_d = {shift_rx_q[SPI_DATA_W-2:0], mosi_lvl};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == SPI_CNT_W'(SPI_DATA_W-1)) state_d = DONE;
        end
        // The falling edge that ends the previous byte must not shift the fresh MSB out.
        if (sck_fall && bit_cnt_q != '0) begin
          shift_tx_d = {shift_tx_q[SPI_DATA_W-2:0], 1'b0};
          miso_d     = shift_tx_d[SPI_DATA_W-1];
        end
      end
      DONE: begin
`ifdef SPI_SLAVE_OVERRUN_EN
        if (rx_valid_q && !bus.rx_ready_i) begin
          overrun_d = 1'b1;
        end else begin
          rx_data_d  = shift_rx_q;
          rx_valid_d = 1'b1;
        end
`else
        rx_data_d  = shift_rx_q;
        rx_valid_d = 1'b1;
`endif
        state_d = cs_lvl ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase

    if (cs_rise) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end

    if (bus.tx_valid_i && !hold_full_q) begin
      hold_d      = bus.tx_data_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_tx_q  <= '0;
      shift_rx_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_tx_q  <= shift_tx_d;
      shift_rx_q  <= shift_rx_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      overrun_q   <= overrun_d;
    end
  end

  assign MISO           = miso_q;
  assign bus.tx_ready_o = ~hold_full_q;
  assign bus.rx_data_o  = rx_data_q;
  assign bus.rx_valid_o = rx_valid_q;
  assign bus.busy_o     = (state_q == SHIFT);
`ifdef SPI_SLAVE_OVERRUN_EN
  assign bus.rx_overrun_o = overrun_q;
`else
  assign bus.rx_overrun_o = 1'b0;
  logic unused_overrun;
  assign unused_overrun = overrun_q ^ overrun_d;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bit-banged SPI master, RX scoreboard with a separate monitor.
module tb_spi_slave;
  logic clk = 1'b0;
  logic reset_i, sck, cs, mosi, miso;
  int   total = 0, bad = 0, rx_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] r0, r1;
  int   c0;

  always #5 clk = ~clk;

  spi_slave_if bus();

  spi_slave #(.SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
    .clk_i(clk), .reset_i(reset_i), .SCK(sck), .CS(cs), .MOSI(mosi), .MISO(miso), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted RX byte must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset_i && bus.rx_valid_o && bus.rx_ready_i) begin
      rx_cnt++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rx_unexpected: got=%h want=none", bus.rx_data_o);
      end else begin
        chk("rx_data", {24'h0, bus.rx_data_o}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_tx(input logic [7:0] d);
    int w = 0;
    while (!bus.tx_ready_o && w < 200) begin tick(); w++; end
    if (!bus.tx_ready_o) begin
      total++; bad++;
      $display("FAIL tx_ready_timeout: got=0 want=1");
    end
    bus.tx_data_i  = d;
    bus.tx_valid_i = 1'b1;
    tick();
    bus.tx_valid_i = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = mo[i];
      tick(4);
      sck   = 1'b1;
      mi[i] = miso;
      tick(4);
      sck = 1'b0;
    end
  endtask

  task automatic frame(input int n, input logic [7:0] m0, input logic [7:0] m1,
                       output logic [7:0] o0, output logic [7:0] o1);
    cs = 1'b0;
    tick(8);
    send_bits(m0, 8, o0);
    if (n > 1) send_bits(m1, 8, o1);
    else o1 = 8'h00;
    tick(4);
    cs = 1'b1;
    tick(12);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    bus.tx_data_i = 8'h00; bus.tx_valid_i = 1'b0; bus.rx_ready_i = 1'b1;
    tick(4);
    chk("rst_miso",     {31'h0, miso},             0);
    chk("rst_tx_ready", {31'h0, bus.tx_ready_o},   1);
    chk("rst_rx_valid", {31'h0, bus.rx_valid_o},   0);
    chk("rst_rx_data",  {24'h0, bus.rx_data_o},    0);
    chk("rst_busy",     {31'h0, bus.busy_o},       0);
    reset_i = 1'b0;
    tick(4);

    // Queued byte goes out while master's byte comes in.
    push_tx(8'hA5);
    chk("t1_tx_ready_full", {31'h0, bus.tx_ready_o}, 0);
    c0 = rx_cnt;
    exp_q.push_back(8'h3C);
    frame(1, 8'h3C, 8'h00, r0, r1);
    chk("t1_miso", {24'h0, r0}, 32'hA5);
    chk("t1_rx_once", rx_cnt - c0, 1);
    chk("t1_tx_ready_empty", {31'h0, bus.tx_ready_o}, 1);

    // Underrun shifts IDLE_BYTE.
    exp_q.push_back(8'hFF);
    frame(1, 8'hFF, 8'h00, r0, r1);
    chk("t2_miso_idle", {24'h0, r0}, 32'h00);

    // Two bytes back to back; second TX byte written mid-frame.
    push_tx(8'h11);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h5A);
    c0 = rx_cnt;
    fork
      frame(2, 8'hC3, 8'h5A, r0, r1);
      begin tick(30); push_tx(8'h22); end
    join
    chk("t3_miso0", {24'h0, r0}, 32'h11);
    chk("t3_miso1", {24'h0, r1}, 32'h22);
    chk("t3_rx_twice", rx_cnt - c0, 2);

    // Abort after 5 bits.
    c0 = rx_cnt;
    cs = 1'b0;
    tick(8);
    send_bits(8'hF0, 5, r0);
    chk("t4_busy_mid", {31'h0, bus.busy_o}, 1);
    cs = 1'b1;
    tick(10);
    chk("t4_miso_zero", {31'h0, miso}, 0);
    chk("t4_busy_idle", {31'h0, bus.busy_o}, 0);
    chk("t4_no_rx", rx_cnt - c0, 0);
    exp_q.push_back(8'h81);
    frame(1, 8'h81, 8'h00, r0, r1);
    chk("t4_miso_next", {24'h0, r0}, 32'h00);

    // Consumer stalled across two received bytes.
    bus.rx_ready_i = 1'b0;
    frame(2, 8'h01, 8'h02, r0, r1);
    chk("t5_rx_valid", {31'h0, bus.rx_valid_o}, 1);
`ifdef SPI_SLAVE_OVERRUN_EN
    chk("t5_rx_data", {24'h0, bus.rx_data_o}, 32'h01);
    chk("t5_overrun", {31'h0, bus.rx_overrun_o}, 1);
    exp_q.push_back(8'h01);
`else
    chk("t5_rx_data", {24'h0, bus.rx_data_o}, 32'h02);
    chk("t5_overrun", {31'h0, bus.rx_overrun_o}, 0);
    exp_q.push_back(8'h02);
`endif
    bus.rx_ready_i = 1'b1;
    tick(3);
    chk("t5_rx_cleared", {31'h0, bus.rx_valid_o}, 0);

    // Reset pulse mid-frame.
    cs = 1'b0;
    tick(8);
    send_bits(8'hAA, 4, r0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("t6_miso",     {31'h0, miso},             0);
    chk("t6_tx_ready", {31'h0, bus.tx_ready_o},   1);
    chk("t6_rx_valid", {31'h0, bus.rx_valid_o},   0);
    chk("t6_rx_data",  {24'h0, bus.rx_data_o},    0);
    chk("t6_overrun",  {31'h0, bus.rx_overrun_o}, 0);
    chk("t6_busy",     {31'h0, bus.busy_o},       0);
    cs = 1'b1;
    tick(12);
    exp_q.push_back(8'h7E);
    frame(1, 8'h7E, 8'h00, r0, r1);
    chk("t6_miso_next", {24'h0, r0}, 32'h00);

    tick(10);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
